// File: rtl/nic_traffic_pkg.sv
// Shared types and field-layout helpers for the NIC traffic generator.
// Flit layout, MSB first: VC | dest | src | [timestamp] | ... | seq (LSBs).
package nic_traffic_pkg;

  typedef enum logic [1:0] {
    MODE_UNIFORM   = 2'd0,
    MODE_TRANSPOSE = 2'd1,
    MODE_NEIGHBOUR = 2'd2,
    MODE_HOTSPOT   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_e;

  typedef enum logic [2:0] {FLD_VC, FLD_DEST, FLD_SRC, FLD_TS, FLD_SEQ} field_e;

  localparam int TS_BITS = 8;

  function automatic int router_id_bits(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

  function automatic int vc_bits(input int nvc);
    return (nvc > 1) ? $clog2(nvc) : 1;
  endfunction

  // LSB offset of a flit field; header fields pack down from the top of the word.
  function automatic int flit_off(input field_e f, input int width, input int id_bits,
                                  input int vcb);
    case (f)
      FLD_VC:   return width - vcb;
      FLD_DEST: return width - vcb - id_bits;
      FLD_SRC:  return width - vcb - 2 * id_bits;
      FLD_TS:   return width - vcb - 2 * id_bits - TS_BITS;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/nic_lfsr8.sv
// 8-bit maximal-length Fibonacci LFSR (taps 8,6,5,4), advances only when stepped.
module nic_lfsr8 #(
  parameter logic [7:0] SEED = 8'h01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step_i,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q, lfsr_d;

  // Shift left, feed back XOR of taps 8,6,5,4.
  always_comb begin
    lfsr_d = lfsr_q;
    if (step_i) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // State register, reloads the seed on reset.
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/nic_traffic_gen.sv
// Per-node synthetic traffic source/sink for a router NIC port.
// Optional feature: define NIC_TRAFFIC_GEN_LATENCY_EN to stamp a free-running
// cycle counter into each flit and accumulate receive latency (lat_sum/lat_max).
module nic_traffic_gen
  import nic_traffic_pkg::*;
#(
  parameter int         ROW_COUNT       = 5,
  parameter int         COL_COUNT       = 5,
  parameter int         NUM_VC          = 4,
  parameter int         NODE_ID         = 0,
  parameter int         SEQ_BITS        = 11,
  parameter int         RATE_BITS       = 8,
  parameter logic [7:0] LFSR_SEED       = 8'hA5,
  parameter int         FLIT_DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [1:0]                 mode,
  input  logic [RATE_BITS-1:0]       rate,
  input  logic [15:0]                num_flits,
  input  logic                       out_ready,
  output logic                       nic_output_valid,
  output logic [FLIT_DATA_WIDTH-1:0] nic_output_data,
  input  logic                       nic_input_valid,
  input  logic [FLIT_DATA_WIDTH-1:0] nic_input_data,
  output logic                       busy,
  output logic                       done,
  output logic [15:0]                tx_count,
  output logic [15:0]                rx_count,
  output logic [15:0]                rx_err_count
`ifdef NIC_TRAFFIC_GEN_LATENCY_EN
  ,
  output logic [31:0]                lat_sum,
  output logic [7:0]                 lat_max
`endif
);

  localparam int NUM_ROUTERS = ROW_COUNT * COL_COUNT;
  localparam int IDB         = router_id_bits(ROW_COUNT, COL_COUNT);
  localparam int VCB         = vc_bits(NUM_VC);
  localparam int OFF_VC      = flit_off(FLD_VC, FLIT_DATA_WIDTH, IDB, VCB);
  localparam int OFF_DEST    = flit_off(FLD_DEST, FLIT_DATA_WIDTH, IDB, VCB);
  localparam int OFF_SRC     = flit_off(FLD_SRC, FLIT_DATA_WIDTH, IDB, VCB);
  localparam int MY_ROW      = NODE_ID / COL_COUNT;
  localparam int MY_COL      = NODE_ID % COL_COUNT;
  localparam int NBR_DEST    = MY_ROW * COL_COUNT + (MY_COL + 1) % COL_COUNT;
  localparam int TRN_DEST    = MY_COL * COL_COUNT + MY_ROW;
  localparam bit TRANS_OK    = (ROW_COUNT == COL_COUNT);
  localparam logic [7:0] SEED_X = LFSR_SEED ^ 8'(NODE_ID);
  localparam logic [7:0] SEED   = (SEED_X == 8'd0) ? 8'd1 : SEED_X;

  state_e                     state_q, state_d;
  mode_e                      mode_q, mode_d;
  logic [RATE_BITS-1:0]       rate_q, rate_d;
  logic [15:0]                num_q, num_d;
  logic [15:0]                tx_q, tx_d;
  logic [SEQ_BITS-1:0]        seq_q, seq_d;
  logic [VCB-1:0]             vc_q, vc_d;
  logic [FLIT_DATA_WIDTH-1:0] data_q, data_d;
  logic [15:0]                rx_q, rx_d, rx_err_q, rx_err_d;
  logic                       step;
  logic [7:0]                 lfsr, uni_dest;
  logic [RATE_BITS-1:0]       lfsr_ext;
  logic [IDB-1:0]             dest, rx_dest;
  logic [FLIT_DATA_WIDTH-1:0] flit;
  logic                       unused_in;

  nic_lfsr8 #(.SEED(SEED)) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .step_i (step),
    .lfsr_o (lfsr)
  );

  assign lfsr_ext = RATE_BITS'(lfsr);
  assign uni_dest = lfsr % 8'(NUM_ROUTERS);

  // Destination for the flit being built, from the pattern latched at start.
  always_comb begin
    dest = IDB'(uni_dest);
    case (mode_q)
      MODE_TRANSPOSE: if (TRANS_OK) dest = IDB'(TRN_DEST);
      MODE_NEIGHBOUR: dest = IDB'(NBR_DEST);
      MODE_HOTSPOT:   dest = '0;
      default:        ;
    endcase
  end

`ifdef NIC_TRAFFIC_GEN_LATENCY_EN
  localparam int OFF_TS = flit_off(FLD_TS, FLIT_DATA_WIDTH, IDB, VCB);
  logic [7:0]  cyc_q;
  logic [7:0]  lat;
  logic [31:0] lat_sum_q;
  logic [7:0]  lat_max_q;

  assign lat = cyc_q - nic_input_data[OFF_TS +: TS_BITS];

  // Free-running stamp counter plus receive-latency statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q     <= '0;
      lat_sum_q <= '0;
      lat_max_q <= '0;
    end else begin
      cyc_q <= cyc_q + 8'd1;
      if (nic_input_valid) begin
        lat_sum_q <= lat_sum_q + 32'(lat);
        if (lat > lat_max_q) lat_max_q <= lat;
      end
    end
  end

  assign lat_sum = lat_sum_q;
  assign lat_max = lat_max_q;
`endif

  // Assemble the outgoing flit; bits outside the fields stay zero.
  always_comb begin
    flit                    = '0;
    flit[OFF_VC +: VCB]     = vc_q;
    flit[OFF_DEST +: IDB]   = dest;
    flit[OFF_SRC +: IDB]    = IDB'(NODE_ID);
`ifdef NIC_TRAFFIC_GEN_LATENCY_EN
    flit[OFF_TS +: TS_BITS] = cyc_q;
`endif
    flit[SEQ_BITS-1:0]      = seq_q;
  end

  // Injection FSM: draw in RUN, hold the flit in HOLD until the router takes it.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rate_d  = rate_q;
    num_d   = num_q;
    tx_d    = tx_q;
    seq_d   = seq_q;
    vc_d    = vc_q;
    data_d  = data_q;
    step    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mode_d  = mode_e'(mode);
          rate_d  = rate;
          num_d   = num_flits;
          tx_d    = '0;
          seq_d   = '0;
          state_d = (num_flits == 16'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (lfsr_ext <= rate_q) begin
          data_d  = flit;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          tx_d    = tx_q + 16'd1;
          seq_d   = seq_q + SEQ_BITS'(1);
          vc_d    = (vc_q == VCB'(NUM_VC - 1)) ? '0 : vc_q + VCB'(1);
          state_d = (tx_q + 16'd1 == num_q) ? DONE : RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Transmit-side state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_UNIFORM;
      rate_q  <= '0;
      num_q   <= '0;
      tx_q    <= '0;
      seq_q   <= '0;
      vc_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rate_q  <= rate_d;
      num_q   <= num_d;
      tx_q    <= tx_d;
      seq_q   <= seq_d;
      vc_q    <= vc_d;
      data_q  <= data_d;
    end
  end

  assign rx_dest = nic_input_data[OFF_DEST +: IDB];

  // Receive counters: total wraps, misrouted count saturates.
  always_comb begin
    rx_d     = rx_q;
    rx_err_d = rx_err_q;
    if (nic_input_valid) begin
      rx_d = rx_q + 16'd1;
      if (rx_dest != IDB'(NODE_ID) && rx_err_q != 16'hFFFF) rx_err_d = rx_err_q + 16'd1;
    end
  end

  // Receive-side registers, independent of the injection FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_q     <= '0;
      rx_err_q <= '0;
    end else begin
      rx_q     <= rx_d;
      rx_err_q <= rx_err_d;
    end
  end

  // Only the destination field matters to the sink in the default build.
  assign unused_in = ^nic_input_data;

  assign nic_output_valid = (state_q == HOLD);
  assign nic_output_data  = data_q;
  assign busy             = (state_q == RUN) || (state_q == HOLD);
  assign done             = (state_q == DONE);
  assign tx_count         = tx_q;
  assign rx_count         = rx_q;
  assign rx_err_count     = rx_err_q;

endmodule

// File: tb/tb_nic_traffic_gen.sv
// Bench for nic_traffic_gen: one node (NODE_ID 7) under directed and random
// runs, plus a 25-node transpose exchange over an ideal crossbar.
module tb_nic_traffic_gen;

  localparam int W  = 32;
  localparam int NR = 25;
  localparam int ME = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, out_ready, in_v;
  logic [1:0]    mode;
  logic [7:0]    rate;
  logic [15:0]   num;
  logic [W-1:0]  in_d, out_d;
  logic          out_v, busy, done;
  logic [15:0]   tx, rx, rxe;

  nic_traffic_gen #(.NODE_ID(ME)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .rate(rate),
    .num_flits(num), .out_ready(out_ready),
    .nic_output_valid(out_v), .nic_output_data(out_d),
    .nic_input_valid(in_v), .nic_input_data(in_d),
    .busy(busy), .done(done), .tx_count(tx), .rx_count(rx), .rx_err_count(rxe)
  );

  // 25-node exchange
  logic          t_reset, t_start;
  logic [7:0]    t_rate;
  logic [NR-1:0] t_ov, t_iv, t_busy, t_done;
  logic [W-1:0]  t_od [NR];
  logic [W-1:0]  t_id [NR];
  logic [15:0]   t_tx [NR];
  logic [15:0]   t_rx [NR];
  logic [15:0]   t_rxe [NR];

  for (genvar g = 0; g < NR; g++) begin : g_node
    nic_traffic_gen #(.NODE_ID(g)) u (
      .clk(clk), .reset(t_reset), .start(t_start), .mode(2'd1), .rate(t_rate),
      .num_flits(16'd10), .out_ready(1'b1),
      .nic_output_valid(t_ov[g]), .nic_output_data(t_od[g]),
      .nic_input_valid(t_iv[g]), .nic_input_data(t_id[g]),
      .busy(t_busy[g]), .done(t_done[g]), .tx_count(t_tx[g]),
      .rx_count(t_rx[g]), .rx_err_count(t_rxe[g])
    );
  end

  // Ideal network: deliver each valid flit to its destination the same cycle.
  always_comb begin
    t_iv = '0;
    for (int n = 0; n < NR; n++) t_id[n] = '0;
    for (int s = 0; s < NR; s++) begin
      int dd;
      dd = int'(t_od[s][29:25]);
      if (t_ov[s] && dd < NR) begin
        t_iv[dd] = 1'b1;
        t_id[dd] = t_od[s];
      end
    end
  end

  int compared = 0;
  int mism     = 0;
  int seq_exp, vc_exp, rx_exp, err_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected destination from grid coordinates; uniform only needs to be a valid node.
  function automatic int exp_dest(input int m, input int obs);
    int r, c;
    r = ME / 5;
    c = ME % 5;
    case (m)
      0:       return (obs < NR) ? obs : -1;
      1:       return c * 5 + r;
      2:       return r * 5 + (c + 1) % 5;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] flit_exp(input int m, input logic [4:0] obs_dest);
    int d;
    d = exp_dest(m, int'(obs_dest));
    return (32'(vc_exp) << 30) | (32'(d) << 25) | (32'(ME) << 20) | 32'(seq_exp & 'h7FF);
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, out_v, 0);
    chk({tag, "_data"}, out_d, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_tx"}, tx, 0);
    chk({tag, "_rx"}, rx, 0);
    chk({tag, "_rxerr"}, rxe, 0);
  endtask

  // pol: 0 ready always, 1 random ready, 2 stall the first flit 4 cycles.
  task automatic run_tx(input int m, input int rt, input int n, input int pol, input bit rxr);
    logic [W-1:0] prev_d;
    bit prev_stall, fin, last_acc;
    int stall_left, acc, dst;
    @(negedge clk);
    mode = 2'(m); rate = 8'(rt); num = 16'(n); start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("no_valid_yet", out_v, 0);
    seq_exp = 0; acc = 0; prev_stall = 0; fin = 0; last_acc = 0; stall_left = 4;
    prev_d = '0;
    for (int c = 0; c < 4000 && !fin; c++) begin
      @(negedge clk);
      chk("rx_count", rx, 32'(rx_exp));
      chk("rx_err_count", rxe, 32'(err_exp));
      if (last_acc) chk("done_after_last", done, 1);
      if (done) begin
        fin  = 1;
        in_v = 1'b0;
      end else begin
        chk("tx_count", tx, 32'(acc));
        if (prev_stall) chk("hold_stable", out_d, prev_d);
        if (out_v) chk("flit", out_d, flit_exp(m, out_d[29:25]));
        case (pol)
          0:       out_ready = 1'b1;
          1:       out_ready = 1'($urandom_range(0, 1));
          default: begin
            out_ready = !(out_v && stall_left > 0);
            if (out_v && stall_left > 0) stall_left--;
          end
        endcase
        prev_stall = out_v && !out_ready;
        prev_d     = out_d;
        last_acc   = 0;
        if (out_v && out_ready) begin
          acc++; seq_exp++;
          vc_exp = (vc_exp + 1) % 4;
          if (acc == n) last_acc = 1;
        end
        if (rxr && $urandom_range(0, 1) == 1) begin
          dst  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NR - 1)) : ME;
          in_v = 1'b1;
          in_d = (32'(dst) << 25) | ($urandom & 32'h01FF_FFFF);
          rx_exp = (rx_exp + 1) & 'hFFFF;
          if (dst != ME && err_exp < 'hFFFF) err_exp++;
        end else begin
          in_v = 1'b0;
        end
      end
    end
    chk("run_finished", 32'(fin), 1);
    chk("done_end", done, 1);
    chk("busy_end", busy, 0);
    chk("tx_final", tx, 32'(n));
    chk("accepted", 32'(acc), 32'(n));
    out_ready = 1'b0;
  endtask

  initial begin
    bit seen, allbusy;
    int sum;
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; in_v = 1'b0; in_d = '0;
    mode = '0; rate = '0; num = '0;
    t_reset = 1'b1; t_start = 1'b0; t_rate = 8'($urandom_range(100, 255));
    repeat (3) @(negedge clk);
    reset = 1'b0; t_reset = 1'b0;
    chk_zero("reset");
    vc_exp = 0; rx_exp = 0; err_exp = 0;

    // Three local flits and one addressed elsewhere
    for (int i = 0; i < 4; i++) begin
      in_v = 1'b1;
      in_d = (32'((i < 3) ? ME : ME + 1) << 25) | 32'(i);
      @(negedge clk);
    end
    in_v = 1'b0;
    chk("rx_directed", rx, 4);
    chk("rx_err_directed", rxe, 1);
    rx_exp = 4; err_exp = 1;

    // Neighbour pattern, full rate: dest 8, seq 0..4, VC 0,1,2,3,0
    run_tx(2, 255, 5, 0, 0);
    // Backpressure on the first flit, hotspot pattern
    run_tx(3, 255, 2, 2, 0);
    // Random runs with random backpressure and concurrent receive traffic
    for (int k = 0; k < 6; k++)
      run_tx(int'($urandom_range(0, 3)), int'($urandom_range(40, 255)),
             int'($urandom_range(1, 12)), 1, 1);

    // rate 0 never injects
    @(negedge clk);
    mode = 2'd0; rate = 8'd0; num = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0; allbusy = 1;
    repeat (200) begin
      @(negedge clk);
      seen    = seen | out_v;
      allbusy = allbusy & busy;
    end
    chk("rate0_no_valid", 32'(seen), 0);
    chk("rate0_busy", 32'(allbusy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_zero("midrun_reset");
    vc_exp = 0; rx_exp = 0; err_exp = 0;

    // Zero-length run goes straight to done
    num = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("nf0_busy", busy, 0);
    chk("nf0_valid_a", out_v, 0);
    @(negedge clk);
    chk("nf0_done", done, 1);
    chk("nf0_valid_b", out_v, 0);
    chk("nf0_tx", tx, 0);

    // 25-node transpose exchange
    t_start = 1'b1;
    @(negedge clk);
    t_start = 1'b0;
    for (int c = 0; c < 3000 && !(&t_done); c++) @(negedge clk);
    chk("torus_all_done", 32'(&t_done), 1);
    sum = 0;
    for (int n = 0; n < NR; n++) begin
      sum += int'(t_rx[n]);
      chk($sformatf("torus_err_%0d", n), t_rxe[n], 0);
    end
    chk("torus_rx_total", 32'(sum), 250);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule

// File: doc/nic_traffic_gen.md
# nic_traffic_gen

Parametrised per-node synthetic traffic generator and sink. It attaches to one router's NIC port in `torus_topology` and replaces hand-written injection stimulus with a programmable, repeatable source. It injects a configured number of flits using a selectable destination pattern at a programmable rate, honours downstream backpressure, and counts and checks the flits it receives.

## Interface
Parameters:
- `ROW_COUNT`, default 5: mesh rows.
- `COL_COUNT`, default 5: mesh columns.
- `NUM_VC`, default 4: virtual channels per port.
- `NODE_ID`, default 0: this node's router index, row-major (`row*COL_COUNT+col`).
- `SEQ_BITS`, default 11: sequence-number field width.
- `RATE_BITS`, default 8: injection-rate and LFSR width.
- `LFSR_SEED`, default 8'hA5: non-zero seed, XORed with `NODE_ID`; a zero result is forced to 1.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle pulse that begins a run.
- `mode` in 2: destination pattern. 0 uniform, 1 transpose, 2 neighbour, 3 hotspot.
- `rate` in `RATE_BITS`: injection probability, `rate`/255.
- `num_flits` in 16: flits to send in this run.
- `out_ready` in 1: router can accept a flit.
- `nic_output_valid` out 1: flit valid toward router.
- `nic_output_data` out `FLIT_DATA_WIDTH`: flit toward router.
- `nic_input_valid` in 1: flit delivered from router.
- `nic_input_data` in `FLIT_DATA_WIDTH`: delivered flit.
- `busy` out 1: run in progress.
- `done` out 1: run complete; held until the next `start` or `reset`.
- `tx_count` out 16: flits accepted by the router in this run.
- `rx_count` out 16: flits received; wraps.
- `rx_err_count` out 16: received flits whose destination field is not `NODE_ID`; saturates at 16'hFFFF.

## Operation
- Flit fields, MSB first: VC[`VC_BITS`], dest[`ROUTER_ID_BITS`], src[`ROUTER_ID_BITS`], then an optional timestamp. `seq[SEQ_BITS]` occupies the LSBs. Unused bits are 0.
- FSM states:
  - IDLE → RUN on `start`. If `num_flits`==0, IDLE → DONE instead.
  - RUN: each cycle, step the LFSR. If `lfsr <= rate`, build a flit and go to HOLD.
  - HOLD: `nic_output_valid`=1 and the data is stable. On `out_ready`, increment `tx_count`, `seq` and the VC pointer. Then go to DONE if `tx_count+1==num_flits`, else back to RUN.
  - DONE → RUN on `start`, with counters `tx_count` and `seq` cleared.
- `start` is ignored in RUN and HOLD. `mode`, `rate` and `num_flits` are sampled only on `start`.
- The LFSR is a maximal-length 8-bit Fibonacci LFSR with taps 8,6,5,4, range 1..255:
  - `rate`=0 never injects.
  - `rate`=255 injects every RUN cycle.
- Destination by mode:
  - Uniform: `lfsr % NUM_ROUTERS`.
  - Transpose: (r,c)→(c,r). Falls back to uniform if `ROW_COUNT`≠`COL_COUNT`.
  - Neighbour: (r,(c+1) mod `COL_COUNT`).
  - Hotspot: node 0.
  - Self-destination is legal.
- VC field: round-robin 0..`NUM_VC`-1, advancing per accepted flit.
- Receive side is independent of the FSM. Every cycle with `nic_input_valid`, `rx_count`++. If dest≠`NODE_ID`, `rx_err_count`++ (saturating).

## Timing
- Reset values: FSM=IDLE. `nic_output_valid`, `nic_output_data`, `busy`, `done`, `tx_count`, `rx_count`, `rx_err_count`, VC pointer and `seq` all 0. LFSR = seed.
- `start` at edge N gives `busy`=1 at N+1. The earliest `nic_output_valid` is at N+2.
- All outputs are registered; there is no combinational path from input to output.
- `valid` is held until `out_ready`, and the data is unchanged while held.
- `done` rises the cycle after the last acceptance, together with `busy`=0.
- `reset` mid-run drops `nic_output_valid` the next cycle and discards the in-flight flit.
- A simultaneous receive and transmit are both counted in the same cycle.

## Configuration
- `NIC_TRAFFIC_GEN_LATENCY_EN` defined:
  - A free-running 8-bit cycle counter is stamped into the timestamp field.
  - The receive side adds outputs `lat_sum` (32-bit, 8-bit modular latency accumulated) and `lat_max` (8-bit), both reset to 0.
- Macro undefined: no timestamp field, no counter, no latency ports.

## Structure
- `nic_traffic_pkg` holds:
  - the mode enum;
  - the state typedef {IDLE, RUN, HOLD, DONE};
  - `ROUTER_ID_BITS`/`VC_BITS` helper functions;
  - a flit field-offset function.
- One sub-module, `nic_lfsr8`: seeded, step-enabled LFSR.

## Test plan
- `NODE_ID`=7, mode 2, `rate`=255, `num_flits`=5, `out_ready`=1:
  - 5 flits with dest 8, seq 0..4, VC 0,1,2,3,0;
  - `done`=1 after the 5th acceptance, `tx_count`=5.
- `out_ready` low for 4 cycles while valid: data is stable, and `tx_count` increments only once when ready rises.
- `rate`=0, `num_flits`=3: no `valid` for 200 cycles, `busy` stays 1. `reset` then clears everything to 0.
- `num_flits`=0, `start`: `done`=1 two cycles later, and no flit is emitted.
- Feed `nic_input` with 3 flits of dest `NODE_ID` and 1 of dest `NODE_ID`+1: `rx_count`=4, `rx_err_count`=1.
- 5×5 torus, all 25 nodes in mode 1 with 10 flits each: the total of all `rx_count` values is 250, and every `rx_err_count` is 0.
